// File: rtl/ncu_mcu_dn_arb.sv
// NCU-to-MCU downstream arbiter.
// Three requesters (READ, WRITE, IFILL) compete round-robin for a 4-bit
// link to the MCU. A granted request becomes a 5-nibble packet: a command
// nibble followed by its 16-bit payload, most significant nibble first.
// The MCU can stall the link at any cycle. A sticky flag reports stalls
// that have lasted too long.
module ncu_mcu_dn_arb #(
    parameter logic [7:0] STALL_LIMIT = 8'd255
) (
    input  logic        iol2clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [47:0] payload,
    output logic [2:0]  ack,
    input  logic        mcu_ncu_stall,
    output logic        ncu_mcu_vld,
    output logic [3:0]  ncu_mcu_data,
    output logic        busy,
    output logic        stall_timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [2:0] LAST_BEAT = 3'd5;

    state_t      state_q;
    logic [2:0]  nxt_q;
    logic [15:0] pay_q;
    logic [1:0]  lastGrant_q;
    logic        vld_q;
    logic [3:0]  data_q;
    logic [2:0]  ack_q;
    logic        busy_q;
    logic [7:0]  stallCnt_q;
    logic [7:0]  stallCnt_d;
    logic        timeout_q;

    logic [1:0]  cand0;
    logic [1:0]  cand1;
    logic [1:0]  cand2;
    logic [1:0]  sel;
    logic        grantAny;
    logic [15:0] selPayload;
    logic [3:0]  selCmd;
    logic [3:0]  beatNibble;

    // Requester index that follows i in the cyclic order 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] nextIdx(input logic [1:0] i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Round-robin pick: search starts one past the most recent grant.
    always_comb begin
        cand0    = nextIdx(lastGrant_q);
        cand1    = nextIdx(cand0);
        cand2    = nextIdx(cand1);
        sel      = cand0;
        grantAny = 1'b0;
        if (req[cand0]) begin
            sel      = cand0;
            grantAny = 1'b1;
        end else if (req[cand1]) begin
            sel      = cand1;
            grantAny = 1'b1;
        end else if (req[cand2]) begin
            sel      = cand2;
            grantAny = 1'b1;
        end
    end

    // Payload slice and command nibble belonging to the selected requester.
    always_comb begin
        selCmd = {2'b01, sel};
        case (sel)
            2'd0:    selPayload = payload[15:0];
            2'd1:    selPayload = payload[31:16];
            default: selPayload = payload[47:32];
        endcase
    end

    // Payload nibble for the next beat, most significant nibble first.
    always_comb begin
        case (nxt_q)
            3'd1:    beatNibble = pay_q[15:12];
            3'd2:    beatNibble = pay_q[11:8];
            3'd3:    beatNibble = pay_q[7:4];
            default: beatNibble = pay_q[3:0];
        endcase
    end

    // Consecutive-stall count, cleared by any unstalled cycle, saturating.
    always_comb begin
        if (!mcu_ncu_stall) begin
            stallCnt_d = 8'd0;
        end else if (stallCnt_q >= STALL_LIMIT) begin
            stallCnt_d = stallCnt_q;
        end else begin
            stallCnt_d = stallCnt_q + 8'd1;
        end
    end

    // Arbitration and beat sequencing; every output comes straight from a flop.
    always_ff @(posedge iol2clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            nxt_q       <= 3'd0;
            pay_q       <= 16'd0;
            lastGrant_q <= 2'd2;
            vld_q       <= 1'b0;
            data_q      <= 4'd0;
            ack_q       <= 3'b000;
            busy_q      <= 1'b0;
        end else begin
            ack_q <= 3'b000;
            case (state_q)
                IDLE: begin
                    vld_q <= 1'b0;
                    if (grantAny && !mcu_ncu_stall) begin
                        state_q     <= SEND;
                        busy_q      <= 1'b1;
                        vld_q       <= 1'b1;
                        data_q      <= selCmd;
                        ack_q       <= 3'b001 << sel;
                        pay_q       <= selPayload;
                        nxt_q       <= 3'd1;
                        lastGrant_q <= sel;
                    end
                end
                SEND: begin
                    if (mcu_ncu_stall) begin
                        vld_q <= 1'b0;
                    end else if (nxt_q < LAST_BEAT) begin
                        vld_q  <= 1'b1;
                        data_q <= beatNibble;
                        nxt_q  <= nxt_q + 3'd1;
                    end else begin
                        vld_q   <= 1'b0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        nxt_q   <= 3'd0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    vld_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    nxt_q   <= 3'd0;
                end
            endcase
        end
    end

    // Stall counter and its sticky timeout flag; only reset clears the flag.
    always_ff @(posedge iol2clk or posedge rst) begin
        if (rst) begin
            stallCnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            stallCnt_q <= stallCnt_d;
            if (mcu_ncu_stall && (stallCnt_d >= STALL_LIMIT)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign ack           = ack_q;
    assign ncu_mcu_vld   = vld_q;
    assign ncu_mcu_data  = data_q;
    assign busy          = busy_q;
    assign stall_timeout = timeout_q;

endmodule

// File: doc/ncu_mcu_dn_arb.md
NCU_MCU_DN_ARB -- requirements
Module: ncu_mcu_dn_arb

Interface
REQ-001 The block SHALL have one parameter: STALL_LIMIT, default 8'd255, the consecutive-stall cycle count that sets stall_timeout.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-003 Port iol2clk, input, 1 bit: clock for all state.
REQ-004 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 Port req, input, 3 bits: request lines; bit0 = READ_REQ, bit1 = WRITE_REQ, bit2 = IFILL_REQ.
REQ-006 Port payload, input, 48 bits: 16-bit payload per requester; [15:0] READ, [31:16] WRITE, [47:32] IFILL.
REQ-007 Port ack, output, 3 bits: one-cycle grant/capture pulse per requester.
REQ-008 Port mcu_ncu_stall, input, 1 bit: MCU backpressure.
REQ-009 Port ncu_mcu_vld, output, 1 bit: beat valid.
REQ-010 Port ncu_mcu_data, output, 4 bits: beat nibble.
REQ-011 Port busy, output, 1 bit: high while state is SEND.
REQ-012 Port stall_timeout, output, 1 bit: sticky stall-limit flag.

Function
REQ-013 States SHALL be IDLE and SEND; all outputs SHALL be registered.
REQ-014 Packet format SHALL be 5 nibbles: cmd, payload[15:12], [11:8], [7:4], [3:0].
REQ-015 cmd SHALL be 4'b0100 for READ, 4'b0101 for WRITE and 4'b0110 for IFILL.
REQ-016 In IDLE with req != 0 and mcu_ncu_stall = 0, at the clock edge the block SHALL:
- select a requester round-robin, searching from (last_grant+1) mod 3;
- capture its 16-bit payload;
- go to SEND;
- drive ncu_mcu_vld = 1, ncu_mcu_data = cmd and ack[sel] = 1 for exactly the next cycle;
- set next-beat index nxt = 1;
- update last_grant = sel.
REQ-017 In IDLE with mcu_ncu_stall = 1, the block SHALL not grant, SHALL hold ack = 0, and SHALL leave pending requests pending.
REQ-018 In SEND with mcu_ncu_stall = 1 at an edge, the block SHALL drive ncu_mcu_vld = 0 next cycle and SHALL hold ncu_mcu_data and nxt.
REQ-019 In SEND with mcu_ncu_stall = 0 and nxt < 5 at an edge, the block SHALL drive ncu_mcu_vld = 1 and ncu_mcu_data = nibble[nxt] next cycle, and SHALL increment nxt.
REQ-020 In SEND with mcu_ncu_stall = 0 and nxt = 5 at an edge, the block SHALL drive ncu_mcu_vld = 0 next cycle and SHALL go to IDLE.
REQ-021 A packet SHALL thus show exactly 5 vld-high cycles, with vld-low gaps only where stall applies. Unstalled latency from the grant edge to the last beat SHALL be 5 cycles, followed by a minimum of 1 idle cycle between packets.
REQ-022 req and payload SHALL be ignored in SEND.
REQ-023 A requester SHALL hold req and payload until its ack, and SHALL drop req in the ack cycle or re-request.
REQ-024 At most one ack bit SHALL be high in any cycle.
REQ-025 ncu_mcu_data SHALL hold its last value when ncu_mcu_vld = 0.
REQ-026 The stall counter SHALL be 8 bits and count consecutive cycles with mcu_ncu_stall = 1 in any state. It SHALL clear when mcu_ncu_stall = 0 and saturate at STALL_LIMIT.
REQ-027 stall_timeout SHALL set when the stall counter reaches STALL_LIMIT and SHALL stay set until rst.

Reset
REQ-028 On rst assertion, asynchronously: state = IDLE, ncu_mcu_vld = 0, ncu_mcu_data = 0, ack = 0, busy = 0, nxt = 0, stall counter = 0, stall_timeout = 0, last_grant = 2 (READ highest priority first).
REQ-029 rst mid-packet SHALL abort the packet with no further beats.
REQ-030 The first grant SHALL be possible at the first edge after rst deasserts.

Verification
REQ-031 Directed scenario: req = 3'b001, payload[15:0] = 16'hABCD, stall = 0 -> ack = 3'b001 for one cycle; vld high 5 consecutive cycles with data 4, A, B, C, D; busy high through the last beat; then vld = 0.
REQ-032 Directed scenario: after reset, req = 3'b111 held until each ack -> packets in order READ, WRITE, IFILL (cmd 4, 5, 6), each followed by at least 1 idle cycle, ack pulses in that order.
REQ-033 Directed scenario: WRITE payload 16'h1234, stall = 1 for 3 cycles after beat "1" is driven -> vld low for 3 cycles, data holds 1, then beats 2, 3, 4; total vld-high count = 5.
REQ-034 Directed scenario: stall = 1 continuously with req = 3'b010 in IDLE -> ack stays 0; stall_timeout rises after 255 consecutive stall cycles; after stall drops, grant occurs and stall_timeout remains 1.
REQ-035 Directed scenario: rst pulse during beat 2 of a READ packet -> vld = 0, data = 0, ack = 0 immediately; with req = 3'b011 afterward, READ is granted first.
